// File: rtl/hazard_stall_control.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and
// data-memory wait freezes, with a sticky memory-timeout trap and stall statistics.
module hazard_stall_control #(
   parameter logic [7:0]  WAIT_LIMIT = 8'd255,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ID_EX_MemRead,
   input  logic [4:0]       Rd_EX,
   input  logic [4:0]       Rs1_ID,
   input  logic [4:0]       Rs2_ID,
   input  logic             Rs1_Used,
   input  logic             Rs2_Used,
   input  logic             Branch_Taken,
   input  logic             MEM_Access,
   input  logic             Mem_Ready,
   output logic             PC_WEN,
   output logic             IF_ID_WEN,
   output logic             Pipe_WEN,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Flush,
   output logic [1:0]       Hz_State,
   output logic             Mem_Timeout,
   output logic [CNT_W-1:0] Stall_Cnt
);

   // state    | meaning
   // RUN      | normal issue; bubbles/flushes applied combinationally
   // MEM_WAIT | data memory outstanding; Wait_Cnt counts wait cycles
   // TIMEOUT  | memory never answered; pipeline frozen until reset
   typedef enum logic [1:0] {
      RUN      = 2'b00,
      MEM_WAIT = 2'b01,
      TIMEOUT  = 2'b10
   } state_e;

   state_e           state_q, state_d;
   logic [7:0]       wait_q, wait_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             mem_stall;
   logic             load_use;

   assign mem_stall = MEM_Access & ~Mem_Ready;
   assign load_use  = ID_EX_MemRead & (Rd_EX != 5'd0) &
                      ((Rs1_Used & (Rs1_ID == Rd_EX)) | (Rs2_Used & (Rs2_ID == Rd_EX)));

   // Priority: timeout freeze > memory freeze > branch flush > load-use bubble.
   always_comb begin
      PC_WEN      = 1'b1;
      IF_ID_WEN   = 1'b1;
      Pipe_WEN    = 1'b1;
      IF_ID_Flush = 1'b0;
      ID_EX_Flush = 1'b0;
      if (rst) begin
         PC_WEN = 1'b1;
      end else if ((state_q == TIMEOUT) || mem_stall) begin
         PC_WEN    = 1'b0;
         IF_ID_WEN = 1'b0;
         Pipe_WEN  = 1'b0;
      end else if (Branch_Taken) begin
         IF_ID_Flush = 1'b1;
         ID_EX_Flush = 1'b1;
      end else if (load_use) begin
         PC_WEN      = 1'b0;
         IF_ID_WEN   = 1'b0;
         ID_EX_Flush = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      case (state_q)
         RUN: begin
            if (mem_stall) begin
               state_d = MEM_WAIT;
               wait_d  = 8'd1;
            end
         end
         MEM_WAIT: begin
            if (Mem_Ready || !MEM_Access) begin
               state_d = RUN;
               wait_d  = 8'd0;
            end else if (wait_q == WAIT_LIMIT) begin
               state_d = TIMEOUT;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         TIMEOUT: state_d = TIMEOUT;
         default: begin
            state_d = RUN;
            wait_d  = 8'd0;
         end
      endcase
   end

   always_comb begin
      stall_d = stall_q;
      if (!PC_WEN && (stall_q != {CNT_W{1'b1}}))
         stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         wait_q  <= 8'd0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         stall_q <= stall_d;
      end
   end

   assign Hz_State    = state_q;
   assign Mem_Timeout = (state_q == TIMEOUT);
   assign Stall_Cnt   = stall_q;

endmodule

// File: tb/tb_hazard_stall_control.sv
// Scenario bench for hazard_stall_control: expected output vectors are queued
// as each cycle's stimulus is applied and compared once the outputs settle.
module tb_hazard_stall_control;

   logic        clk;
   logic        rst;
   logic        ID_EX_MemRead;
   logic [4:0]  Rd_EX, Rs1_ID, Rs2_ID;
   logic        Rs1_Used, Rs2_Used, Branch_Taken, MEM_Access, Mem_Ready;
   logic        PC_WEN, IF_ID_WEN, Pipe_WEN, IF_ID_Flush, ID_EX_Flush;
   logic [1:0]  Hz_State;
   logic        Mem_Timeout;
   logic [15:0] Stall_Cnt;
   logic        s_pc, s_ifid, s_pipe, s_fi, s_fe, s_to;
   logic [1:0]  s_st;
   logic [2:0]  s_cnt;

   hazard_stall_control #(.WAIT_LIMIT(8'd4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .ID_EX_MemRead(ID_EX_MemRead), .Rd_EX(Rd_EX),
      .Rs1_ID(Rs1_ID), .Rs2_ID(Rs2_ID), .Rs1_Used(Rs1_Used), .Rs2_Used(Rs2_Used),
      .Branch_Taken(Branch_Taken), .MEM_Access(MEM_Access), .Mem_Ready(Mem_Ready),
      .PC_WEN(PC_WEN), .IF_ID_WEN(IF_ID_WEN), .Pipe_WEN(Pipe_WEN),
      .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush), .Hz_State(Hz_State),
      .Mem_Timeout(Mem_Timeout), .Stall_Cnt(Stall_Cnt));

   // Narrow statistics counter so saturation is reachable in a short run.
   hazard_stall_control #(.WAIT_LIMIT(8'd4), .CNT_W(3)) dut_sat (
      .clk(clk), .rst(rst), .ID_EX_MemRead(ID_EX_MemRead), .Rd_EX(Rd_EX),
      .Rs1_ID(Rs1_ID), .Rs2_ID(Rs2_ID), .Rs1_Used(Rs1_Used), .Rs2_Used(Rs2_Used),
      .Branch_Taken(Branch_Taken), .MEM_Access(MEM_Access), .Mem_Ready(Mem_Ready),
      .PC_WEN(s_pc), .IF_ID_WEN(s_ifid), .Pipe_WEN(s_pipe),
      .IF_ID_Flush(s_fi), .ID_EX_Flush(s_fe), .Hz_State(s_st),
      .Mem_Timeout(s_to), .Stall_Cnt(s_cnt));

   typedef struct packed {
      logic [4:0]  ctl;   // {PC_WEN, IF_ID_WEN, Pipe_WEN, IF_ID_Flush, ID_EX_Flush}
      logic [1:0]  st;
      logic        to;
      logic [15:0] cnt;
   } exp_t;

   localparam logic [4:0] NORM = 5'b11100;
   localparam logic [4:0] FRZ  = 5'b00000;
   localparam logic [4:0] LU   = 5'b00101;
   localparam logic [4:0] BR   = 5'b11111;

   exp_t exp_q[$];
   exp_t obs, e;
   int   errors = 0;
   int   checks = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [4:0] ctl, input logic [1:0] st,
                               input logic to, input int cnt);
      exp_t r;
      r.ctl = ctl;
      r.st  = st;
      r.to  = to;
      r.cnt = cnt[15:0];
      return r;
   endfunction

   task automatic idle();
      ID_EX_MemRead = 0; Rd_EX = 0; Rs1_ID = 0; Rs2_ID = 0;
      Rs1_Used = 0; Rs2_Used = 0; Branch_Taken = 0; MEM_Access = 0; Mem_Ready = 0;
   endtask

   task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic u1);
      ID_EX_MemRead = 1; Rd_EX = rd; Rs1_ID = rs1; Rs1_Used = u1;
   endtask

   task automatic sample(input exp_t ex);
      exp_q.push_back(ex);
      #1;
      obs = {PC_WEN, IF_ID_WEN, Pipe_WEN, IF_ID_Flush, ID_EX_Flush, Hz_State, Mem_Timeout, Stall_Cnt};
   endtask

   task automatic test_reset();
      rst = 1; idle();
      MEM_Access = 1; set_lu(5'd5, 5'd5, 1'b1);
      @(negedge clk);
      sample(mk(NORM, 2'b00, 0, 0));
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL reset got=%h exp=%h", obs, e); end
      @(negedge clk); rst = 0; idle();
      sample(mk(NORM, 2'b00, 0, 0));
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL reset_release got=%h exp=%h", obs, e); end
   endtask

   task automatic test_load_use();
      @(negedge clk); set_lu(5'd5, 5'd5, 1'b1);
      sample(mk(LU, 2'b00, 0, 0));
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL load_use_rs1 got=%h exp=%h", obs, e); end
      @(negedge clk); idle();
      sample(mk(NORM, 2'b00, 0, 1));
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL load_use_after got=%h exp=%h", obs, e); end
      @(negedge clk); set_lu(5'd7, 5'd3, 1'b1); Rs2_ID = 5'd7; Rs2_Used = 1;
      sample(mk(LU, 2'b00, 0, 1));
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL load_use_rs2 got=%h exp=%h", obs, e); end
      @(negedge clk); idle();
      sample(mk(NORM, 2'b00, 0, 2));
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL load_use_rs2_after got=%h exp=%h", obs, e); end
   endtask

   task automatic test_no_stall();
      @(negedge clk); set_lu(5'd0, 5'd0, 1'b1);
      sample(mk(NORM, 2'b00, 0, 2));
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL no_stall_rd0 got=%h exp=%h", obs, e); end
      @(negedge clk); idle(); set_lu(5'd5, 5'd5, 1'b0);
      sample(mk(NORM, 2'b00, 0, 2));
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL no_stall_unused got=%h exp=%h", obs, e); end
      @(negedge clk); idle(); set_lu(5'd5, 5'd5, 1'b1); ID_EX_MemRead = 0;
      sample(mk(NORM, 2'b00, 0, 2));
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL no_stall_noload got=%h exp=%h", obs, e); end
      @(negedge clk); idle();
      sample(mk(NORM, 2'b00, 0, 2));
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL no_stall_cnt got=%h exp=%h", obs, e); end
   endtask

   task automatic test_branch();
      @(negedge clk); set_lu(5'd5, 5'd5, 1'b1); Branch_Taken = 1;
      sample(mk(BR, 2'b00, 0, 2));
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL branch_over_lu got=%h exp=%h", obs, e); end
      @(negedge clk); idle();
      sample(mk(NORM, 2'b00, 0, 2));
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL branch_after got=%h exp=%h", obs, e); end
   endtask

   task automatic test_mem_wait();
      @(negedge clk); MEM_Access = 1; Mem_Ready = 0;
      sample(mk(FRZ, 2'b00, 0, 2));
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL mem_wait_c1 got=%h exp=%h", obs, e); end
      @(negedge clk); Branch_Taken = 1;
      sample(mk(FRZ, 2'b01, 0, 3));
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL mem_wait_c2_branch got=%h exp=%h", obs, e); end
      @(negedge clk); Branch_Taken = 0;
      sample(mk(FRZ, 2'b01, 0, 4));
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL mem_wait_c3 got=%h exp=%h", obs, e); end
      @(negedge clk); Mem_Ready = 1;
      sample(mk(NORM, 2'b01, 0, 5));
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL mem_wait_ready got=%h exp=%h", obs, e); end
      @(negedge clk); idle();
      sample(mk(NORM, 2'b00, 0, 5));
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL mem_wait_back_run got=%h exp=%h", obs, e); end
      checks++;
      if (s_cnt !== 3'd5) begin errors++; $display("FAIL sat_cnt_pre got=%0d exp=5", s_cnt); end
      @(negedge clk); MEM_Access = 1;
      sample(mk(FRZ, 2'b00, 0, 5));
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL mem_abort_c1 got=%h exp=%h", obs, e); end
      @(negedge clk); MEM_Access = 0;
      sample(mk(NORM, 2'b01, 0, 6));
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL mem_abort_drop got=%h exp=%h", obs, e); end
      @(negedge clk);
      sample(mk(NORM, 2'b00, 0, 6));
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL mem_abort_run got=%h exp=%h", obs, e); end
   endtask

   task automatic test_timeout();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); MEM_Access = 1; Mem_Ready = 0;
         sample(mk(FRZ, (i == 0) ? 2'b00 : 2'b01, 0, 6 + i));
         e = exp_q.pop_front(); checks++;
         if (obs !== e) begin errors++; $display("FAIL timeout_wait%0d got=%h exp=%h", i, obs, e); end
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); idle(); Mem_Ready = 1; Branch_Taken = 1;
         sample(mk(FRZ, 2'b10, 1, 11 + k));
         e = exp_q.pop_front(); checks++;
         if (obs !== e) begin errors++; $display("FAIL timeout_hold%0d got=%h exp=%h", k, obs, e); end
      end
      checks++;
      if (s_cnt !== 3'd7) begin errors++; $display("FAIL sat_cnt got=%0d exp=7", s_cnt); end
      #1 rst = 1;
      sample(mk(NORM, 2'b00, 0, 0));
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL timeout_async_rst got=%h exp=%h", obs, e); end
      checks++;
      if (s_cnt !== 3'd0) begin errors++; $display("FAIL sat_cnt_rst got=%0d exp=0", s_cnt); end
      @(negedge clk); rst = 0; idle();
      sample(mk(NORM, 2'b00, 0, 0));
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL timeout_resume got=%h exp=%h", obs, e); end
   endtask

   task automatic test_async_reset_mid_wait();
      @(negedge clk); MEM_Access = 1; Mem_Ready = 0;
      sample(mk(FRZ, 2'b00, 0, 0));
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL arst_c1 got=%h exp=%h", obs, e); end
      @(negedge clk);
      sample(mk(FRZ, 2'b01, 0, 1));
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL arst_wait got=%h exp=%h", obs, e); end
      #1 rst = 1;
      sample(mk(NORM, 2'b00, 0, 0));
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL arst_immediate got=%h exp=%h", obs, e); end
      @(negedge clk);
      sample(mk(NORM, 2'b00, 0, 0));
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL arst_held got=%h exp=%h", obs, e); end
      @(negedge clk); rst = 0; idle();
      sample(mk(NORM, 2'b00, 0, 0));
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL arst_release got=%h exp=%h", obs, e); end
      @(negedge clk); set_lu(5'd9, 5'd9, 1'b1);
      sample(mk(LU, 2'b00, 0, 0));
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL arst_lu got=%h exp=%h", obs, e); end
      @(negedge clk); idle();
      sample(mk(NORM, 2'b00, 0, 1));
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL arst_lu_cnt got=%h exp=%h", obs, e); end
   endtask

   initial begin
      rst = 1; idle();
      test_reset();
      test_load_use();
      test_no_stall();
      test_branch();
      test_mem_wait();
      test_timeout();
      test_async_reset_mid_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
